// File: rtl/prince_pkg.sv
// PRINCE constants and round primitives shared by the core and its round datapath.
// Nibble 0 is bits [63:60] everywhere; M' columns are the 16-bit slices [63:48]..[15:0].
package prince_pkg;

    localparam int unsigned ROUNDS = 12;
    localparam logic [63:0] ALPHA  = 64'hc0ac29b7c97c50dd;

    localparam logic [63:0] RC [ROUNDS] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd
    };

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hbf32ac916780e5d4;
        return tbl[6'd60 - {x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hb732fd89a6405ec1;
        return tbl[6'd60 - {x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] s_inv_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
        return y;
    endfunction

    // Output nibble m takes input nibble 5m mod 16; the inverse uses 13 = 5^-1 mod 16.
    function automatic logic [63:0] sr(input logic [63:0] x);
        logic [63:0] y;
        for (int m = 0; m < 16; m++) y[60 - 4*m +: 4] = x[60 - 4*((5*m) % 16) +: 4];
        return y;
    endfunction

    function automatic logic [63:0] sr_inv(input logic [63:0] x);
        logic [63:0] y;
        for (int m = 0; m < 16; m++) y[60 - 4*m +: 4] = x[60 - 4*((13*m) % 16) +: 4];
        return y;
    endfunction

    // Block (j,i) of M-hat0 is M_{(i+j)%4}, of M-hat1 is M_{(i+j+1)%4}; M_k drops bit k.
    function automatic logic [63:0] m_prime(input logic [63:0] x);
        logic [63:0] y;
        int          base;
        int          hat;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            base = 63 - 16 * c;
            hat  = (c == 1 || c == 2) ? 1 : 0;
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    for (int i = 0; i < 4; i++)
                        if ((i + j + hat) % 4 != k)
                            y[base - 4*j - k] = y[base - 4*j - k] ^ x[base - 4*i - k];
        end
        return y;
    endfunction

endpackage

// File: rtl/prince_cipher_if.sv
// Host-side bus of the PRINCE core: block/key in, ciphertext and done pulse out.
// The decrypt select exists only when PRINCE_DECRYPT_EN is defined.
interface prince_cipher_if;
    logic [63:0]  plaintext;
    logic [127:0] key;
`ifdef PRINCE_DECRYPT_EN
    logic         decrypt;
`endif
    logic [63:0]  ciphertext;
    logic         done;

    modport master (
        output plaintext, key,
`ifdef PRINCE_DECRYPT_EN
        output decrypt,
`endif
        input  ciphertext, done
    );

    modport slave (
        input  plaintext, key,
`ifdef PRINCE_DECRYPT_EN
        input  decrypt,
`endif
        output ciphertext, done
    );
endinterface

// File: rtl/prince_round.sv
// Combinational PRINCE round: forward (cnt 1..5), middle (cnt 6), inverse (cnt 7..11).
// Zero latency; no flow control. One shared M' instance serves all three round kinds.
module prince_round
    import prince_pkg::*;
(
    input  logic [3:0]  cnt_i,
    input  logic [63:0] state_i,
    input  logic [63:0] k1_i,
    output logic [63:0] state_o
);

    logic        inv_phase;
    logic [3:0]  rc_idx;
    logic [63:0] rc;
    logic [63:0] mp_in;
    logic [63:0] mp_out;

    always_comb begin
        inv_phase = (cnt_i >= 4'd7);
        rc_idx    = inv_phase ? cnt_i - 4'd1 : cnt_i;
        rc        = (rc_idx < 4'(ROUNDS)) ? RC[rc_idx] : '0;
        // Forward and middle rounds feed M' from the S-layer, inverse rounds from SR^-1.
        mp_in     = inv_phase ? sr_inv(state_i ^ k1_i ^ rc) : s_layer(state_i);
        mp_out    = m_prime(mp_in);
        if (cnt_i <= 4'd5) state_o = sr(mp_out) ^ rc ^ k1_i;
        else               state_o = s_inv_layer(mp_out);
    end

endmodule

// File: rtl/prince_cipher_top.sv
// PRINCE core, one round per clock; loads every 12 cycles, result 11 edges after the load edge.
// No backpressure: free-running, host holds inputs across loads. PRINCE_DECRYPT_EN adds decrypt.
module prince_cipher_top
    import prince_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    prince_cipher_if.slave bus
);

    logic [3:0]  cnt_q,   cnt_d;
    logic [63:0] state_q, state_d;
    logic [63:0] k0p_q,   k0p_d;
    logic [63:0] k1_q,    k1_d;
    logic [63:0] ct_q,    ct_d;
    logic        done_q,  done_d;

    logic [63:0] k0_in, k0p_in, pre_key, post_key, k1_sel, round_out;
    logic        load, last;

    prince_round u_round (
        .cnt_i   (cnt_q),
        .state_i (state_q),
        .k1_i    (k1_q),
        .state_o (round_out)
    );

    always_comb begin
        k0_in    = bus.key[127:64];
        k0p_in   = {k0_in[0], k0_in[63:1]} ^ {63'd0, k0_in[63]};
        pre_key  = k0_in;
        post_key = k0p_in;
        k1_sel   = bus.key[63:0];
`ifdef PRINCE_DECRYPT_EN
        // Alpha reflection: decryption is encryption with k0/k0' swapped and k1 ^ alpha.
        if (bus.decrypt) begin
            pre_key  = k0p_in;
            post_key = k0_in;
            k1_sel   = bus.key[63:0] ^ ALPHA;
        end
`endif
    end

    // The pre-whitening key is consumed at load, so only k0' and k1 are held for the block.
    always_comb begin
        load    = (cnt_q == 4'd0);
        last    = (cnt_q == 4'(ROUNDS - 1));
        cnt_d   = last ? 4'd0 : cnt_q + 4'd1;
        state_d = round_out;
        k0p_d   = k0p_q;
        k1_d    = k1_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = bus.plaintext ^ pre_key ^ k1_sel ^ RC[0];
            k0p_d   = post_key;
            k1_d    = k1_sel;
        end
        if (last) begin
            ct_d   = round_out ^ RC[ROUNDS - 1] ^ k1_q ^ k0p_q;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= '0;
            k0p_q   <= '0;
            k1_q    <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            k0p_q   <= k0p_d;
            k1_q    <= k1_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
        end
    end

    assign bus.ciphertext = ct_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_prince_cipher_top.sv
// Bench for prince_cipher_top: known-answer vectors, async reset abort and random blocks,
// all checked each cycle against a whole-block PRINCE reference function.
module tb_prince_cipher_top;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    prince_cipher_if bus ();

    prince_cipher_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ALPHA_T = 64'hc0ac29b7c97c50dd;
    localparam logic [63:0] RCT [12] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd
    };
    localparam logic [3:0] SBT [16] = '{4'hb, 4'hf, 4'h3, 4'h2, 4'ha, 4'hc, 4'h9, 4'h1,
                                        4'h6, 4'h7, 4'h8, 4'h0, 4'he, 4'h5, 4'hd, 4'h4};
    localparam logic [3:0] SIT [16] = '{4'hb, 4'h7, 4'h3, 4'h2, 4'hf, 4'hd, 4'h8, 4'h9,
                                        4'ha, 4'h6, 4'h4, 4'h0, 4'h5, 4'he, 4'hc, 4'h1};
    localparam int SRF [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    localparam int SRI [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    // Column images of M-hat0 (first 16) and M-hat1 (last 16), input bit b -> output mask.
    localparam logic [15:0] MPT [32] = '{
        16'h0111, 16'h2220, 16'h4404, 16'h8088, 16'h1011, 16'h0222, 16'h4440, 16'h8808,
        16'h1101, 16'h2022, 16'h0444, 16'h8880, 16'h1110, 16'h2202, 16'h4044, 16'h0888,
        16'h1110, 16'h2202, 16'h4044, 16'h0888, 16'h0111, 16'h2220, 16'h4404, 16'h8088,
        16'h1011, 16'h0222, 16'h4440, 16'h8808, 16'h1101, 16'h2022, 16'h0444, 16'h8880};

    function automatic logic [63:0] t_s(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = inv ? SIT[x[4*n +: 4]] : SBT[x[4*n +: 4]];
        return y;
    endfunction

    function automatic logic [63:0] t_sr(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        for (int m = 0; m < 16; m++) y[63 - 4*m -: 4] = x[63 - 4*(inv ? SRI[m] : SRF[m]) -: 4];
        return y;
    endfunction

    function automatic logic [63:0] t_mp(input logic [63:0] x);
        logic [63:0] y;
        logic [15:0] c, o;
        y = '0;
        for (int ch = 0; ch < 4; ch++) begin
            c = x[16*ch +: 16];
            o = '0;
            for (int b = 0; b < 16; b++)
                if (c[b]) o = o ^ MPT[(ch == 0 || ch == 3) ? b : 16 + b];
            y[16*ch +: 16] = o;
        end
        return y;
    endfunction

    function automatic logic [63:0] prince_ref(input logic [63:0] pt, input logic [127:0] key,
                                                input bit dec);
        logic [63:0] k0, k0p, k1, kin, kout, s;
        k0   = key[127:64];
        k1   = key[63:0];
        k0p  = {k0[0], k0[63:1]} ^ {63'd0, k0[63]};
        kin  = k0;
        kout = k0p;
        if (dec) begin
            kin  = k0p;
            kout = k0;
            k1   = k1 ^ ALPHA_T;
        end
        s = pt ^ kin ^ k1 ^ RCT[0];
        for (int r = 1; r <= 5; r++) s = t_sr(t_mp(t_s(s, 1'b0)), 1'b0) ^ RCT[r] ^ k1;
        s = t_s(t_mp(t_s(s, 1'b0)), 1'b1);
        for (int r = 6; r <= 10; r++) s = t_s(t_mp(t_sr(s ^ k1 ^ RCT[r], 1'b1)), 1'b1);
        return s ^ RCT[11] ^ k1 ^ kout;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Timing model: edges counted from reset release; every 12th is a load whose result
    // appears 11 edges later together with a single-cycle done.
    int          m_edge = 0;
    int          m_due  = -1;
    logic [63:0] m_pend = '0;
    logic [63:0] m_ct   = '0;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_edge <= 0;
            m_due  <= -1;
            m_ct   <= '0;
            m_done <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            m_done <= 1'b0;
            if (m_edge % 12 == 0) begin
`ifdef PRINCE_DECRYPT_EN
                m_pend <= prince_ref(bus.plaintext, bus.key, bus.decrypt);
`else
                m_pend <= prince_ref(bus.plaintext, bus.key, 1'b0);
`endif
                m_due  <= m_edge + 11;
            end
            if (m_edge == m_due) begin
                m_ct   <= m_pend;
                m_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("ciphertext", bus.ciphertext, m_ct);
        check("done", {63'd0, bus.done}, {63'd0, m_done});
    end

    typedef struct {
        logic [63:0] pt;
        logic [63:0] k0;
        logic [63:0] k1;
        logic [63:0] ct;
    } vec_t;

    vec_t vecs [5] = '{
        '{64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000, 64'h818665aa0d02dfda},
        '{64'hffffffffffffffff, 64'h0000000000000000, 64'h0000000000000000, 64'h604ae6ca03c20ada},
        '{64'h0000000000000000, 64'hffffffffffffffff, 64'h0000000000000000, 64'h9fb51935fc3df524},
        '{64'h0000000000000000, 64'h0000000000000000, 64'hffffffffffffffff, 64'h78a54cbe737bb7ef},
        '{64'h0123456789abcdef, 64'h0000000000000000, 64'hfedcba9876543210, 64'hae25ad3ca8fa9ccf}
    };

    task automatic drive(input logic [63:0] pt, input logic [127:0] key, input bit dec);
        bus.plaintext = pt;
        bus.key       = key;
`ifdef PRINCE_DECRYPT_EN
        bus.decrypt   = dec;
`else
        if (dec) $display("decrypt request ignored in encrypt-only build");
`endif
    endtask

    task automatic run_block(input string name, input logic [63:0] exp);
        repeat (12) @(posedge clk);
        #1;
        check({name, "_ct"}, bus.ciphertext, exp);
        check({name, "_done"}, {63'd0, bus.done}, 64'd1);
    endtask

    initial begin
        drive('0, '0, 1'b0);
        #3;
        check("reset_ct", bus.ciphertext, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);

        for (int v = 0; v < 5; v++)
            check($sformatf("model_kat%0d", v),
                  prince_ref(vecs[v].pt, {vecs[v].k0, vecs[v].k1}, 1'b0), vecs[v].ct);

        @(negedge clk);
        reset = 1'b1;
        for (int v = 0; v < 5; v++) begin
            drive(vecs[v].pt, {vecs[v].k0, vecs[v].k1}, 1'b0);
            run_block($sformatf("kat%0d", v), vecs[v].ct);
        end
`ifdef PRINCE_DECRYPT_EN
        check("model_dec", prince_ref(64'hae25ad3ca8fa9ccf, {64'd0, 64'hfedcba9876543210}, 1'b1),
              64'h0123456789abcdef);
        drive(64'hae25ad3ca8fa9ccf, {64'd0, 64'hfedcba9876543210}, 1'b1);
        run_block("kat_dec", 64'h0123456789abcdef);
`endif

        // Abort a block at cycle 5, then confirm a clean restart after release.
        drive(64'h0123456789abcdef, {64'd0, 64'hfedcba9876543210}, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_ct", bus.ciphertext, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_block("restart", 64'hae25ad3ca8fa9ccf);

        for (int b = 0; b < 40; b++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
`ifdef PRINCE_DECRYPT_EN
                  1'($urandom_range(0, 1))
`else
                  1'b0
`endif
            );
            repeat (12) @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
